// File: rtl/chain_max_select.sv
// Chaining-DP reduction: f(i) = max(init, max_j sat(f(j)+score(i,j))) with best-predecessor tracking.
// Optional feature: define CHAIN_SKIP_EN to stop evaluating after MAX_SKIP consecutive non-improving beats.
module chain_max_select #(
    parameter int IDX_W    = 16,
    parameter int CNT_W    = 7,
    parameter int MAX_SKIP = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [31:0]      start_init,
    input  logic [CNT_W-1:0] start_npred,
    input  logic             score_valid,
    input  logic [31:0]      score,
    input  logic [31:0]      pred_f,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_f,
    output logic [IDX_W-1:0] out_pred,
    output logic             out_has_pred,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t             state, state_nxt;
    logic signed [31:0] best;
    logic [IDX_W-1:0]   pred;
    logic               has_pred;
    logic [CNT_W-1:0]   remaining;
    logic               err_q;

    logic signed [32:0] sum;
    logic signed [31:0] cand;
    logic               beat, improve, eval_en;

    assign sum  = {pred_f[31], pred_f} + {score[31], score};
    assign beat = (state == ACCUM) && score_valid;

    // The two top bits of the 33-bit sum disagree exactly when the 32-bit result overflowed.
    always_comb begin
        case (sum[32:31])
            2'b01:   cand = 32'sh7FFF_FFFF;
            2'b10:   cand = 32'sh8000_0000;
            default: cand = sum[31:0];
        endcase
    end

`ifdef CHAIN_SKIP_EN
    localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
    logic [SKIP_W-1:0] skip;

    assign eval_en = (skip < SKIP_W'(MAX_SKIP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            skip <= '0;
        else if (state == IDLE && start_valid)
            skip <= '0;
        else if (beat && eval_en)
            skip <= improve ? '0 : skip + SKIP_W'(1);
    end
`else
    assign eval_en = 1'b1;
`endif

    assign improve = eval_en && (cand > best);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid) state_nxt = (start_npred != '0) ? ACCUM : OUT;
            ACCUM:   if (beat && remaining == CNT_W'(1)) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best      <= '0;
            pred      <= '1;
            has_pred  <= 1'b0;
            remaining <= '0;
        end else if (state == IDLE && start_valid) begin
            best      <= start_init;
            pred      <= '1;
            has_pred  <= 1'b0;
            remaining <= start_npred;
        end else if (beat) begin
            remaining <= remaining - CNT_W'(1);
            if (improve) begin
                best     <= cand;
                pred     <= pred_idx;
                has_pred <= 1'b1;
            end
        end
    end

    // Beats outside ACCUM have no anchor to belong to; flag and drop them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            err_q <= 1'b0;
        else if (score_valid && state != ACCUM) err_q <= 1'b1;
    end

    assign start_ready  = (state == IDLE);
    assign out_valid    = (state == OUT);
    assign out_f        = best;
    assign out_pred     = pred;
    assign out_has_pred = has_pred;
    assign err          = err_q;

endmodule

// File: tb/tb_chain_max_select.sv
// Self-checking bench for chain_max_select: directed vector table, hand sequences, randomized anchors vs a model.
module tb_chain_max_select;

    localparam int IDX_W    = 16;
    localparam int CNT_W    = 7;
    localparam int MAX_SKIP = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_valid, start_ready;
    logic [31:0]      start_init;
    logic [CNT_W-1:0] start_npred;
    logic             score_valid;
    logic [31:0]      score, pred_f;
    logic [IDX_W-1:0] pred_idx;
    logic             out_valid, out_ready;
    logic [31:0]      out_f;
    logic [IDX_W-1:0] out_pred;
    logic             out_has_pred, err;

    chain_max_select #(.IDX_W(IDX_W), .CNT_W(CNT_W), .MAX_SKIP(MAX_SKIP)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_init(start_init), .start_npred(start_npred),
        .score_valid(score_valid), .score(score), .pred_f(pred_f), .pred_idx(pred_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_pred(out_pred), .out_has_pred(out_has_pred), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] b_pf[64];
    logic [31:0] b_sc[64];
    logic [15:0] b_idx[64];

    typedef struct packed {
        logic [31:0]      init;
        logic [6:0]       n;
        logic [2:0][31:0] pf;
        logic [2:0][31:0] sc;
        logic [2:0][15:0] idx;
        logic [31:0]      ef;
        logic [15:0]      ep;
        logic             eh;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [31:0] init, input int n,
                                input logic [31:0] pf0, sc0, input logic [15:0] i0,
                                input logic [31:0] pf1, sc1, input logic [15:0] i1,
                                input logic [31:0] pf2, sc2, input logic [15:0] i2,
                                input logic [31:0] ef, input logic [15:0] ep, input logic eh);
        vec_t v;
        v.init = init; v.n = n[6:0];
        v.pf[0] = pf0; v.sc[0] = sc0; v.idx[0] = i0;
        v.pf[1] = pf1; v.sc[1] = sc1; v.idx[1] = i1;
        v.pf[2] = pf2; v.sc[2] = sc2; v.idx[2] = i2;
        v.ef = ef; v.ep = ep; v.eh = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit values, clamped, running max with strict improvement.
    function automatic void model(input logic [31:0] init, input int n,
                                  output logic [31:0] f, output logic [15:0] p, output logic h);
        longint bestv, c;
        int     skip;
        bestv = $signed(init);
        skip  = 0;
        p = 16'hFFFF;
        h = 1'b0;
        for (int k = 0; k < n; k++) begin
            c = longint'($signed(b_pf[k])) + longint'($signed(b_sc[k]));
            if (c > 64'sd2147483647)  c = 64'sd2147483647;
            if (c < -64'sd2147483648) c = -64'sd2147483648;
`ifdef CHAIN_SKIP_EN
            if (skip >= MAX_SKIP) continue;
`endif
            if (c > bestv) begin
                bestv = c; p = b_idx[k]; h = 1'b1; skip = 0;
            end else begin
                skip++;
            end
        end
        f = bestv[31:0];
    endfunction

    task automatic run(input string nm, input logic [31:0] init, input int n, input bit gaps,
                       input int hold, input logic [31:0] ef, input logic [15:0] ep, input logic eh);
        @(negedge clk);
        chk({nm, ".start_ready"}, start_ready, 1);
        start_valid = 1'b1; start_init = init; start_npred = n[CNT_W-1:0];
        @(negedge clk);
        start_valid = 1'b0; start_init = $urandom;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    chk({nm, ".gap_valid"}, out_valid, 0);
                    @(negedge clk);
                end
            end
            score_valid = 1'b1; score = b_sc[k]; pred_f = b_pf[k]; pred_idx = b_idx[k];
            @(negedge clk);
            score_valid = 1'b0; score = $urandom; pred_f = $urandom; pred_idx = 16'($urandom);
        end
        chk({nm, ".out_valid"}, out_valid, 1);
        chk({nm, ".out_f"}, out_f, ef);
        chk({nm, ".out_pred"}, out_pred, ep);
        chk({nm, ".out_has_pred"}, out_has_pred, eh);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk({nm, ".hold_valid"}, out_valid, 1);
            chk({nm, ".hold_f"}, out_f, ef);
            chk({nm, ".hold_pred"}, {out_pred, out_has_pred}, {ep, eh});
            chk({nm, ".hold_start_ready"}, start_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, ".post_valid"}, out_valid, 0);
        chk({nm, ".post_ready"}, start_ready, 1);
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 3))
            0:       rv = 32'h7FFF_FF00 + $urandom_range(0, 255);
            1:       rv = 32'h8000_0000 + $urandom_range(0, 255);
            default: rv = 32'(int'($urandom_range(0, 2000)) - 1000);
        endcase
    endfunction

    initial begin
        logic [31:0] ef;
        logic [15:0] ep;
        logic        eh;
        int          n;

        reset = 1'b0; start_valid = 1'b0; start_init = '0; start_npred = '0;
        score_valid = 1'b0; score = '0; pred_f = '0; pred_idx = '0; out_ready = 1'b0;

        vecs[0] = mk(32'd10, 3, 32'd20, 32'd5, 16'd7, 32'd30, -32'sd2, 16'd8, 32'd25, 32'd3, 16'd9,
                     32'd28, 16'd8, 1'b1);
        vecs[1] = mk(32'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd15, 16'hFFFF, 1'b0);
        vecs[2] = mk(32'd100, 2, 32'd10, 32'd5, 16'd1, 32'd20, -32'sd3, 16'd2, 0, 0, 0,
                     32'd100, 16'hFFFF, 1'b0);
        vecs[3] = mk(32'd0, 1, 32'h7FFF_FFF0, 32'h20, 16'd3, 0, 0, 0, 0, 0, 0,
                     32'h7FFF_FFFF, 16'd3, 1'b1);
        vecs[4] = mk(32'h8000_0000, 1, 32'h8000_0010, 32'hFFFF_FF00, 16'd4, 0, 0, 0, 0, 0, 0,
                     32'h8000_0000, 16'hFFFF, 1'b0);
`ifdef CHAIN_SKIP_EN
        vecs[5] = mk(32'd10, 3, 32'd5, 0, 16'd1, 32'd6, 0, 16'd2, 32'd50, 0, 16'd3,
                     32'd10, 16'hFFFF, 1'b0);
`else
        vecs[5] = mk(32'd10, 3, 32'd5, 0, 16'd1, 32'd6, 0, 16'd2, 32'd50, 0, 16'd3,
                     32'd50, 16'd3, 1'b1);
`endif

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst.start_ready", start_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_f", out_f, 0);
        chk("rst.out_pred", out_pred, 16'hFFFF);
        chk("rst.out_has_pred", out_has_pred, 0);
        chk("rst.err", err, 0);

        // Directed table; the first vector also exercises output back-pressure.
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 3; k++) begin
                b_pf[k] = vecs[v].pf[k]; b_sc[k] = vecs[v].sc[k]; b_idx[k] = vecs[v].idx[k];
            end
            run($sformatf("vec%0d", v), vecs[v].init, int'(vecs[v].n), 1'b0, (v == 0) ? 5 : 0,
                vecs[v].ef, vecs[v].ep, vecs[v].eh);
        end
        chk("table.err", err, 0);

        // Overrun in IDLE sets a sticky error.
        @(negedge clk);
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        chk("ovr.err", err, 1);
        chk("ovr.start_ready", start_ready, 1);
        b_pf[0] = 32'd1; b_sc[0] = 32'd1; b_idx[0] = 16'd5;
        run("ovr.next", 32'd0, 1, 1'b0, 0, 32'd2, 16'd5, 1'b1);
        chk("ovr.err_sticky", err, 1);

        // Reset after 1 of 3 beats: no result, back to IDLE, error cleared.
        @(negedge clk);
        start_valid = 1'b1; start_init = 32'd0; start_npred = 7'd3;
        @(negedge clk);
        start_valid = 1'b0;
        score_valid = 1'b1; score = 32'd100; pred_f = 32'd0; pred_idx = 16'd9;
        @(negedge clk);
        score_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mrst.out_valid", out_valid, 0);
        chk("mrst.start_ready", start_ready, 1);
        chk("mrst.err", err, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mrst.idle_valid", out_valid, 0);
            chk("mrst.idle_ready", start_ready, 1);
        end
        chk("mrst.out_has_pred", out_has_pred, 0);

        // Randomized anchors against the model.
        for (int t = 0; t < 60; t++) begin
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(9, 40)) : int'($urandom_range(0, 8));
            for (int k = 0; k < n; k++) begin
                b_pf[k] = rv(); b_sc[k] = rv(); b_idx[k] = 16'($urandom);
            end
            start_init = rv();
            model(start_init, n, ef, ep, eh);
            run($sformatf("rnd%0d", t), start_init, n, 1'b1, int'($urandom_range(0, 2)), ef, ep, eh);
        end
        chk("rnd.err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chain_max_select.md
# chain_max_select

Chaining-DP reduction stage that sits directly downstream of the pairwise score pipeline (`computeScorepp`). For each anchor i it receives the stream of pairwise scores score(i,j), one per predecessor j, together with the already-final f(j) and index j. It computes f(i) = max(init_i, max_j(f(j)+score(i,j))) and the best predecessor index, then hands the result to the chain writer through a valid/ready handshake.

## Interface
Parameters:
- `IDX_W`, 16: width of the anchor index.
- `CNT_W`, 7: width of the predecessor count; supports up to 2^CNT_W−1 predecessors.
- `MAX_SKIP`, 25: non-improving predecessor limit. Used only with `CHAIN_SKIP_EN`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted at 0).
- `start_valid` input 1: a new anchor i is offered.
- `start_ready` output 1: high only in IDLE.
- `start_init` input 32: signed initial score of anchor i.
- `start_npred` input CNT_W: number of scores that will follow for this anchor.
- `score_valid` input 1: score beat present. There is no back-pressure; a beat is consumed in the cycle it is presented.
- `score` input 32: signed score(i,j) from the score pipeline.
- `pred_f` input 32: signed f(j). The caller delay-matches it to `score`.
- `pred_idx` input IDX_W: j. The caller delay-matches it to `score`.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_f` output 32: signed f(i).
- `out_pred` output IDX_W: best j; all-ones when there is no predecessor.
- `out_has_pred` output 1: 1 if some predecessor beat `start_init`.
- `err` output 1: sticky error flag; cleared only by reset.

## Operation
State machine with three states: IDLE, ACCUM, OUT.
- IDLE:
  - On `start_valid`: latch best=`start_init`, pred=all-ones, has_pred=0, remaining=`start_npred`, skip=0.
  - Next state is ACCUM if `start_npred`≠0, otherwise OUT.
- ACCUM:
  - Each `score_valid` beat forms cand = sat32(sext33(`pred_f`)+sext33(`score`)).
  - sat32 clamps to the 32-bit signed range: values above the maximum become 0x7FFFFFFF; values below the minimum become 0x80000000.
  - If cand > best (signed, strict), then best=cand, pred=`pred_idx`, has_pred=1. A tie therefore keeps the earlier predecessor.
  - remaining decrements on every beat. The beat that takes remaining to 0 moves the state to OUT.
- OUT:
  - `out_valid`=1 and the outputs are driven from the best/pred/has_pred registers.
  - On `out_ready`, return to IDLE.
  - While `out_ready`=0, all outputs hold stable.
- `score_valid` in IDLE or OUT is an overrun: the beat is ignored and `err` is set to 1.
- `start_valid` outside IDLE is not accepted (`start_ready`=0). The offer must be held by the upstream.

## Timing
- Reset values: `start_ready`=1 after release; `out_valid`=0, `out_f`=0, `out_pred`=all-ones, `out_has_pred`=0, `err`=0; state=IDLE.
- Start accepted at edge E0 → ACCUM from E0. The first score beat may arrive in the cycle immediately after E0.
- Last score beat sampled at edge En → `out_valid`=1 in the cycle after En. Latency from the last beat to the result is 1 cycle.
- `start_npred`=0 → `out_valid`=1 in the cycle after E0.
- Result handshake at edge Eh → IDLE and `start_ready`=1 after Eh. The minimum anchor period is npred+2 cycles.
- Add, compare and update complete in a single cycle, so full-rate beats (one per cycle) are supported.
- Reset asserted mid-ACCUM or mid-OUT: the block returns to IDLE immediately. The partial result is discarded and never emitted.

## Configuration
- `CHAIN_SKIP_EN` defined:
  - A skip counter increments on each ACCUM beat that does not improve best, and resets to 0 on each beat that does.
  - Once skip reaches `MAX_SKIP`, the remaining beats for the anchor are still consumed and counted, but do not update best/pred.
- `CHAIN_SKIP_EN` undefined: every beat is evaluated and `MAX_SKIP` is unused.

## Test plan
- Basic max with tie:
  - Stimulus: init=10, npred=3; beats (pred_f,score,idx) = (20,5,7), (30,−2,8), (25,3,9).
  - Response: `out_f`=28, `out_pred`=8, `out_has_pred`=1.
- Zero predecessors:
  - Stimulus: npred=0, init=15.
  - Response: one cycle after start, `out_valid`=1, `out_f`=15, `out_pred`=0xFFFF, `out_has_pred`=0.
- No improvement:
  - Stimulus: init=100; beats (10,5,1), (20,−3,2).
  - Response: `out_f`=100, `out_has_pred`=0.
- Saturation:
  - Stimulus: `pred_f`=0x7FFFFFF0, `score`=0x20.
  - Response: `out_f`=0x7FFFFFFF.
  - Stimulus: `pred_f`=0x80000010, `score`=0xFFFFFF00 with init=0x80000000.
  - Response: `out_has_pred`=0.
- Back-pressure and errors:
  - Stimulus: hold `out_ready`=0 for 5 cycles.
  - Response: outputs stable and `start_ready`=0 throughout.
  - Stimulus: pulse `score_valid` in IDLE.
  - Response: `err`=1 until reset.
  - Stimulus: assert reset after 1 of 3 beats.
  - Response: no `out_valid`; block is in IDLE.
- `CHAIN_SKIP_EN`:
  - Stimulus: `MAX_SKIP`=2, init=10, candidates 5, 6, 50.
  - Response: `out_f`=10, `out_has_pred`=0.
  - Stimulus: same beats with the macro undefined.
  - Response: `out_f`=50.
